// File: rtl/serial_frame_tx.sv
// serial_frame_tx: LSB-first serial frame transmitter.
// Frame: start bit (0), DATA_W data bits, optional even-parity bit, STOP_BITS
// stop bits (1). Every bit is held for CLKS_PER_BIT clk cycles.
// Optional feature macro: PARITY_EN (adds one even-parity bit after the data).
// Handshake: a word transfers on a rising edge where valid_in and ready_out are
// both high; ready_out is high in IDLE and in the last cycle of the last stop
// bit, so a waiting producer gets back-to-back frames with no idle gap.
// dbg_state exposes the FSM state (0=IDLE 1=START 2=DATA 3=PARITY 4=STOP).
module serial_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic              tx_out,
   output logic              busy,
   output logic [2:0]        dbg_state
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam int BW = $clog2(DATA_W + 1);

   localparam logic [CW-1:0] C_LOAD   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_ONE    = CW'(1);
   localparam logic [CW-1:0] C_ZERO   = CW'(0);
   localparam logic [BW-1:0] C_NBITS  = BW'(DATA_W);
   localparam logic [BW-1:0] C_BIT1   = BW'(1);
   localparam logic          C_STOP_LOAD = 1'(STOP_BITS - 1);
   // With one-cycle bits and a single stop bit, the stop bit is its own last cycle.
   localparam logic          C_FAST_RDY  = (CLKS_PER_BIT == 1) && (STOP_BITS == 1);
   localparam logic          C_CPB_ONE   = (CLKS_PER_BIT == 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
   logic [CW-1:0]     r_cnt;
   logic [BW-1:0]     r_bit_cnt;
   logic              r_stop_cnt;
   logic              r_tx;
   logic              r_busy;
   logic              r_ready;
`ifdef PARITY_EN
   logic              r_parity;
`endif

   // Frame sequencer: state, counters, shift register and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_cnt      <= C_ZERO;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_ready    <= 1'b1;
`ifdef PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
               if (valid_in) begin
                  r_state <= S_START;
                  r_shift <= data_in;
                  r_cnt   <= C_LOAD;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
`ifdef PARITY_EN
                  r_parity <= ^data_in;
`endif
               end
            end

            S_START: begin
               if (r_cnt == C_ZERO) begin
                  r_state   <= S_DATA;
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= C_BIT1;
                  r_cnt     <= C_LOAD;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end

            S_DATA: begin
               if (r_cnt == C_ZERO) begin
                  if (r_bit_cnt == C_NBITS) begin
`ifdef PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_parity;
                     r_cnt   <= C_LOAD;
`else
                     r_state    <= S_STOP;
                     r_tx       <= 1'b1;
                     r_cnt      <= C_LOAD;
                     r_stop_cnt <= C_STOP_LOAD;
                     r_ready    <= C_FAST_RDY;
`endif
                  end else begin
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + C_BIT1;
                     r_cnt     <= C_LOAD;
                  end
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end

            S_PARITY: begin
               if (r_cnt == C_ZERO) begin
                  r_state    <= S_STOP;
                  r_tx       <= 1'b1;
                  r_cnt      <= C_LOAD;
                  r_stop_cnt <= C_STOP_LOAD;
                  r_ready    <= C_FAST_RDY;
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end

            S_STOP: begin
               if (r_cnt != C_ZERO) begin
                  // ready rises for the final cycle of the final stop bit.
                  r_cnt   <= r_cnt - C_ONE;
                  r_ready <= (r_cnt == C_ONE) && !r_stop_cnt;
               end else if (r_stop_cnt) begin
                  r_stop_cnt <= 1'b0;
                  r_cnt      <= C_LOAD;
                  r_ready    <= C_CPB_ONE;
               end else if (valid_in) begin
                  // Back-to-back accept: next start bit follows with no gap.
                  r_state <= S_START;
                  r_shift <= data_in;
                  r_cnt   <= C_LOAD;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_ready <= 1'b0;
`ifdef PARITY_EN
                  r_parity <= ^data_in;
`endif
               end else begin
                  r_state <= S_IDLE;
                  r_tx    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign ready_out = r_ready;
   assign tx_out    = r_tx;
   assign busy      = r_busy;
   assign dbg_state = r_state;

endmodule
